// File: rtl/acc_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_cpu: multi-cycle accumulator CPU (FETCH/EXEC) with unified mem.  |
// | Optional program-load port enabled by defining CPU_LOAD_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module acc_cpu #(
  parameter int    DWIDTH    = 8,
  parameter int    AWIDTH    = 5,
  parameter string INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
`ifdef CPU_LOAD_EN
  input  logic              LD_WE,
  input  logic [AWIDTH-1:0] LD_ADDR,
  input  logic [DWIDTH-1:0] LD_DATA,
`endif
  output logic              HALT,
  output logic              CARRY,
  output logic [AWIDTH-1:0] PC_OUT,
  output logic [DWIDTH-1:0] AC_OUT
);

  localparam int       c_DEPTH  = 2**AWIDTH;
  localparam bit [2:0] c_OP_HLT = 3'd0;
  localparam bit [2:0] c_OP_SKZ = 3'd1;
  localparam bit [2:0] c_OP_ADD = 3'd2;
  localparam bit [2:0] c_OP_AND = 3'd3;
  localparam bit [2:0] c_OP_XOR = 3'd4;
  localparam bit [2:0] c_OP_LDA = 3'd5;
  localparam bit [2:0] c_OP_STO = 3'd6;
  localparam bit [2:0] c_OP_JMP = 3'd7;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] r_ac;
  logic [DWIDTH-1:0] r_ir;
  logic              r_carry;
  logic              r_halt;
  logic [DWIDTH-1:0] r_mem [0:c_DEPTH-1];

  logic [2:0]        w_opcode;
  logic [AWIDTH-1:0] w_operand;
  logic [DWIDTH-1:0] w_rvalue;
  logic [DWIDTH:0]   w_sum;
  logic              w_sto;

  assign w_opcode  = r_ir[DWIDTH-1 -: 3];
  assign w_operand = r_ir[AWIDTH-1:0];
  assign w_rvalue  = r_mem[w_operand];
  assign w_sum     = {1'b0, r_ac} + {1'b0, w_rvalue};
  assign w_sto     = EN && (r_state == S_EXEC) && (w_opcode == c_OP_STO);

  // IR bits between opcode and operand carry no meaning
  generate
    if (DWIDTH > AWIDTH + 3) begin : g_ir_gap
      logic w_unused_gap;
      assign w_unused_gap = ^r_ir[DWIDTH-4:AWIDTH];
    end
  endgenerate

  // Memory is not reset; load writes only land while the core is frozen
  always_ff @(posedge CLK) begin
    if (w_sto) begin
      r_mem[w_operand] <= r_ac;
    end
`ifdef CPU_LOAD_EN
    else if (!EN && LD_WE) begin
      r_mem[LD_ADDR] <= LD_DATA;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ac    <= '0;
      r_ir    <= '0;
      r_carry <= 1'b0;
      r_halt  <= 1'b0;
    end else if (EN) begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= r_mem[r_pc];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          r_pc    <= r_pc + AWIDTH'(1);
          case (w_opcode)
            c_OP_HLT: begin
              r_pc    <= r_pc;
              r_state <= S_HALTED;
              r_halt  <= 1'b1;
            end
            c_OP_SKZ: if (r_ac == '0) r_pc <= r_pc + AWIDTH'(2);
            c_OP_ADD: {r_carry, r_ac} <= w_sum;
            c_OP_AND: r_ac <= r_ac & w_rvalue;
            c_OP_XOR: r_ac <= r_ac ^ w_rvalue;
            c_OP_LDA: r_ac <= w_rvalue;
            c_OP_JMP: r_pc <= w_operand;
            default: ;
          endcase
        end
        default: begin
          r_state <= S_HALTED;
          r_halt  <= 1'b1;
        end
      endcase
    end
  end

  assign HALT   = r_halt;
  assign CARRY  = r_carry;
  assign PC_OUT = r_pc;
  assign AC_OUT = r_ac;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_acc_cpu: directed scoreboard bench for acc_cpu.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_acc_cpu;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic       LD_WE = 1'b0;
  logic [4:0] LD_ADDR = '0;
  logic [7:0] LD_DATA = '0;
  logic       HALT, CARRY;
  logic [4:0] PC_OUT;
  logic [7:0] AC_OUT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 CLK = ~CLK;

  acc_cpu #(.DWIDTH(8), .AWIDTH(5), .INIT_FILE("")) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
`ifdef CPU_LOAD_EN
    .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
`endif
    .HALT(HALT), .CARRY(CARRY), .PC_OUT(PC_OUT), .AC_OUT(AC_OUT)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [15:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
`ifdef CPU_LOAD_EN
    EN = 1'b0; LD_WE = 1'b1; LD_ADDR = a; LD_DATA = d;
    @(negedge CLK);
    LD_WE = 1'b0;
`else
    dut.r_mem[a] = d;
`endif
  endtask

  task automatic pulse_reset();
    RST = 1'b1; #1; RST = 1'b0;
  endtask

  task automatic run(input int n);
    EN = 1'b1;
    repeat (n) @(negedge CLK);
    EN = 1'b0;
  endtask

  task automatic load_basic(input logic [7:0] a, input logic [7:0] b);
    load(5'd0, 8'hB0); load(5'd1, 8'h51); load(5'd2, 8'hD2); load(5'd3, 8'h00);
    load(5'd16, a); load(5'd17, b);
  endtask

  initial begin
    // reset state, checked before any clock edge
    #1;
    expect_val("rst_halt", 16'h0);  check({15'd0, HALT});
    expect_val("rst_pc", 16'h0);    check({11'd0, PC_OUT});
    expect_val("rst_ac", 16'h0);    check({8'd0, AC_OUT});
    expect_val("rst_carry", 16'h0); check({15'd0, CARRY});
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 32; i++) load(i[4:0], 8'h00);

    // basic program: LDA 16, ADD 17, STO 18, HLT
    load_basic(8'h05, 8'h07);
    pulse_reset();
    expect_val("basic_halt_edge7", 16'h0);
    run(7); check({15'd0, HALT});
    expect_val("basic_halt", 16'h1);
    expect_val("basic_ac", 16'h0C);
    expect_val("basic_carry", 16'h0);
    expect_val("basic_pc", 16'h3);
    expect_val("basic_mem18", 16'h0C);
    run(1);
    check({15'd0, HALT}); check({8'd0, AC_OUT}); check({15'd0, CARRY});
    check({11'd0, PC_OUT}); check({8'd0, dut.r_mem[18]});
    expect_val("hold_halt", 16'h1);
    expect_val("hold_pc", 16'h3);
    run(6);
    check({15'd0, HALT}); check({11'd0, PC_OUT});

    // carry out of ADD
    load(5'd16, 8'hFF); load(5'd17, 8'h02);
    pulse_reset();
    expect_val("carry_ac", 16'h01);
    expect_val("carry_flag", 16'h1);
    expect_val("carry_mem18", 16'h01);
    run(8);
    check({8'd0, AC_OUT}); check({15'd0, CARRY}); check({8'd0, dut.r_mem[18]});

    // async reset between edges, observed without a clock edge
    EN = 1'b1;
    RST = 1'b1;
    #1;
    expect_val("arst_halt", 16'h0);  check({15'd0, HALT});
    expect_val("arst_pc", 16'h0);    check({11'd0, PC_OUT});
    expect_val("arst_ac", 16'h0);    check({8'd0, AC_OUT});
    expect_val("arst_carry", 16'h0); check({15'd0, CARRY});
    RST = 1'b0;
    EN = 1'b0;
    @(negedge CLK);

    // SKZ at top address wraps: AC==0 -> PC=1
    load(5'd0, 8'hFF); load(5'd31, 8'h20);
    pulse_reset();
    expect_val("skz_zero_pc", 16'h1);
    run(4);
    check({11'd0, PC_OUT});
    // AC!=0 -> PC=0; CARRY untouched by non-ADD
    load(5'd0, 8'hB0); load(5'd1, 8'hFF); load(5'd16, 8'h03);
    pulse_reset();
    expect_val("skz_nz_pc", 16'h0);
    expect_val("skz_nz_ac", 16'h03);
    expect_val("skz_nz_carry", 16'h0);
    run(6);
    check({11'd0, PC_OUT}); check({8'd0, AC_OUT}); check({15'd0, CARRY});

    // EN freeze between FETCH and EXEC of ADD
    load_basic(8'h05, 8'h07);
    pulse_reset();
    run(3);
    repeat (5) @(negedge CLK);
    expect_val("frz_pc", 16'h1);
    expect_val("frz_ac", 16'h05);
    expect_val("frz_halt", 16'h0);
    check({11'd0, PC_OUT}); check({8'd0, AC_OUT}); check({15'd0, HALT});
    expect_val("resume_halt", 16'h1);
    expect_val("resume_ac", 16'h0C);
    expect_val("resume_pc", 16'h3);
    run(5);
    check({15'd0, HALT}); check({8'd0, AC_OUT}); check({11'd0, PC_OUT});

`ifdef CPU_LOAD_EN
    // load strobe ignored while running
    EN = 1'b1; LD_WE = 1'b1; LD_ADDR = 5'd16; LD_DATA = 8'hAA;
    @(negedge CLK);
    LD_WE = 1'b0; EN = 1'b0;
    expect_val("ld_gate_mem16", 16'h05);
    check({8'd0, dut.r_mem[16]});
`endif

    // self-modifying: STO 2 overwrites a JMP 0 with HLT
    load(5'd0, 8'hB4); load(5'd1, 8'hC2); load(5'd2, 8'hE0); load(5'd20, 8'h00);
    pulse_reset();
    expect_val("smc_halt_edge5", 16'h0);
    run(5);
    check({15'd0, HALT});
    expect_val("smc_halt_edge6", 16'h1);
    expect_val("smc_pc", 16'h2);
    run(1);
    check({15'd0, HALT}); check({11'd0, PC_OUT});

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
